// File: rtl/candidate_generator.sv
// Odometer-order password candidate source feeding the MD5 controller over valid/ready.
// Optional feature macro: CANDIDATE_COUNT_EN adds the accepted_count output.
//
// state   | meaning
// IDLE    | waiting for start
// ADVANCE | stepping the odometer, remaining_q steps left
// EMIT    | candidate presented, waiting for out_ready
// DONE    | keyspace exhausted, waiting for start or stop
module candidate_generator #(
    parameter logic [7:0] CHAR_MIN = 8'h61,
    parameter logic [7:0] CHAR_MAX = 8'h7A,
    parameter int         MAX_LEN  = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [0:7]   start_offset,
    input  logic [2:0]   stride,
    input  logic         stop,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [0:127] guess,
    output logic [0:7]   guess_width,
    output logic         busy,
    output logic         exhausted
`ifdef CANDIDATE_COUNT_EN
    ,
    output logic [0:31]  accepted_count
`endif
);

    typedef enum logic [1:0] {IDLE, ADVANCE, EMIT, DONE} state_t;

    state_t       state_q, state_d;
    logic [7:0]   char_q [MAX_LEN];
    logic [7:0]   char_d [MAX_LEN];
    logic [4:0]   len_q, len_d;
    logic [7:0]   remaining_q, remaining_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] guess_q, guess_d;
    logic [7:0]   width_q, width_d;
    logic         busy_q, busy_d;
    logic         exhausted_q, exhausted_d;
`ifdef CANDIDATE_COUNT_EN
    logic [31:0]  count_q, count_d;
`endif

    logic [7:0]   step_char [MAX_LEN];
    logic [4:0]   step_len;
    logic         step_wrap;
    logic [7:0]   stride_steps;

    // Position 0 holds the rightmost (last) character.
    function automatic logic [127:0] pack_guess(input logic [7:0] c [MAX_LEN], input logic [4:0] l);
        logic [127:0] g;
        g = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(l)) g[8*i +: 8] = c[i];
        end
        return g;
    endfunction

    always_comb begin : odometer_step
        logic carry;
        carry     = 1'b1;
        step_len  = len_q;
        step_wrap = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            step_char[i] = char_q[i];
            if (carry && (i < int'(len_q))) begin
                if (char_q[i] == CHAR_MAX) begin
                    step_char[i] = CHAR_MIN;
                end else begin
                    step_char[i] = char_q[i] + 8'd1;
                    carry        = 1'b0;
                end
            end
        end
        if (carry) begin
            if (len_q == 5'(MAX_LEN)) step_wrap = 1'b1;
            else                      step_len  = len_q + 5'd1;
            for (int i = 0; i < MAX_LEN; i++) step_char[i] = CHAR_MIN;
        end
    end

    assign stride_steps = (stride == 3'd0) ? 8'd1 : {5'd0, stride};

    always_comb begin
        state_d     = state_q;
        char_d      = char_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        guess_d     = guess_q;
        width_d     = width_q;
        exhausted_d = exhausted_q;
`ifdef CANDIDATE_COUNT_EN
        count_d     = count_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    for (int i = 0; i < MAX_LEN; i++) char_d[i] = CHAR_MIN;
                    len_d       = 5'd1;
                    exhausted_d = 1'b0;
`ifdef CANDIDATE_COUNT_EN
                    count_d     = '0;
`endif
                    if (start_offset == 8'd0) begin
                        state_d     = EMIT;
                        out_valid_d = 1'b1;
                        guess_d     = {120'd0, CHAR_MIN};
                        width_d     = 8'd8;
                    end else begin
                        state_d     = ADVANCE;
                        remaining_d = start_offset;
                    end
                end else if (state_q == DONE && stop) begin
                    state_d = IDLE;
                end
            end
            ADVANCE: begin
                if (stop) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else if (step_wrap) begin
                    state_d     = DONE;
                    exhausted_d = 1'b1;
                    out_valid_d = 1'b0;
                end else begin
                    char_d      = step_char;
                    len_d       = step_len;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d     = EMIT;
                        out_valid_d = 1'b1;
                        guess_d     = pack_guess(step_char, step_len);
                        width_d     = {step_len, 3'b000};
                    end
                end
            end
            EMIT: begin
                // stop beats a simultaneous handshake
                if (stop) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else if (out_ready) begin
                    state_d     = ADVANCE;
                    remaining_d = stride_steps;
                    out_valid_d = 1'b0;
`ifdef CANDIDATE_COUNT_EN
                    if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ADVANCE) || (state_d == EMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < MAX_LEN; i++) char_q[i] <= CHAR_MIN;
            len_q       <= 5'd1;
            remaining_q <= 8'd0;
            out_valid_q <= 1'b0;
            guess_q     <= '0;
            width_q     <= 8'd0;
            busy_q      <= 1'b0;
            exhausted_q <= 1'b0;
`ifdef CANDIDATE_COUNT_EN
            count_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            char_q      <= char_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            guess_q     <= guess_d;
            width_q     <= width_d;
            busy_q      <= busy_d;
            exhausted_q <= exhausted_d;
`ifdef CANDIDATE_COUNT_EN
            count_q     <= count_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign guess       = guess_q;
    assign guess_width = width_q;
    assign busy        = busy_q;
    assign exhausted   = exhausted_q;
`ifdef CANDIDATE_COUNT_EN
    assign accepted_count = count_q;
`endif

endmodule
